// File: rtl/mips_pkg.sv
// Shared opcode constants, FSM state encoding and PC-source encoding for the
// IF / IF_ID pipeline sequencer.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MEM_WAIT   = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        PC_SRC_PLUS4  = 2'b00,
        PC_SRC_BRANCH = 2'b01,
        PC_SRC_JUMP   = 2'b10
    } pc_src_t;

    // Jumps always redirect; conditional branches only when the ID compare says taken.
    function automatic pc_src_t redirect_sel(input logic [5:0] opcode, input logic branch_taken);
        pc_src_t sel;
        sel = PC_SRC_PLUS4;
        case (opcode)
            OP_J, OP_JAL:                     sel = PC_SRC_JUMP;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: sel = branch_taken ? PC_SRC_BRANCH : PC_SRC_PLUS4;
            default:                          sel = PC_SRC_PLUS4;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the EX-stage load and the ID-stage
// source registers; purely combinational.
module hazard_detect
    import mips_pkg::*;
(
    input  logic [5:0] id_opcode,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       rt_is_source,
    output logic       hazard
);

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        rt_is_source = 1'b0;
        case (id_opcode)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SW, OP_SB, OP_SH: rt_is_source = 1'b1;
            default:                                       rt_is_source = 1'b0;
        endcase
    end

    // $zero is never really written, so a load targeting it cannot create a dependency.
    assign hazard = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (rt_is_source && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// IF / IF_ID pipeline sequencer: load-use stalls, branch/jump redirects and
// instruction-memory wait states. Control outputs are combinational from state.
module pipeline_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter bit DELAY_SLOT        = 1'b1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             imem_ready,
    output logic             pc_load_enable,
    output logic             ifid_load_enable,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       pc_src_sel,
    output logic [CNT_W-1:0] stall_count,
    output logic [1:0]       state_o
);

    localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);

    state_t     state;
    pc_src_t    pending_sel;
    pc_src_t    redir_sel;
    logic [2:0] load_cnt;
    logic       hazard;
    logic       rt_is_source;
    logic       redirect;

    hazard_detect u_hazard_detect (
        .id_opcode   (id_opcode),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .rt_is_source(rt_is_source),
        .hazard      (hazard)
    );

    assign redir_sel = redirect_sel(id_opcode, branch_taken);
    assign redirect  = (redir_sel != PC_SRC_PLUS4);
    assign state_o   = state;

    // Defaults describe a held pipeline; only the advance paths release it.
    always_comb begin
        pc_load_enable   = 1'b0;
        ifid_load_enable = 1'b0;
        ifid_flush       = 1'b0;
        idex_bubble      = 1'b1;
        pc_src_sel       = PC_SRC_PLUS4;
        if (reset) begin
            case (state)
                RUN: begin
                    if (imem_ready && !hazard) begin
                        pc_load_enable   = 1'b1;
                        ifid_load_enable = 1'b1;
                        idex_bubble      = 1'b0;
                        pc_src_sel       = redir_sel;
                        ifid_flush       = redirect && (DELAY_SLOT == 1'b0);
                    end
                end
                MEM_WAIT: begin
                    if (imem_ready) begin
                        pc_load_enable   = 1'b1;
                        ifid_load_enable = 1'b1;
                        idex_bubble      = 1'b0;
                        pc_src_sel       = pending_sel;
                        ifid_flush       = (pending_sel != PC_SRC_PLUS4) && (DELAY_SLOT == 1'b0);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            pending_sel <= PC_SRC_PLUS4;
            load_cnt    <= 3'd0;
            stall_count <= '0;
        end else begin
            if (!pc_load_enable && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + CNT_W'(1);
            case (state)
                RUN: begin
                    if (!imem_ready) begin
                        pending_sel <= redir_sel;
                        state       <= MEM_WAIT;
                    end else if (hazard) begin
                        load_cnt <= STALL_INIT;
                        if (STALL_INIT != 3'd0)
                            state <= LOAD_STALL;
                    end
                end
                LOAD_STALL: begin
                    load_cnt <= load_cnt - 3'd1;
                    if (load_cnt <= 3'd1)
                        state <= RUN;
                end
                MEM_WAIT: begin
                    if (imem_ready) begin
                        pending_sel <= PC_SRC_PLUS4;
                        state       <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table for the RUN-state
// decode plus hand-written stall, wait, reset-abort and saturation sequences.
module tb_pipeline_hazard_ctrl;

    localparam int RTYPE = 'h00, J = 'h02, JAL = 'h03, BEQ = 'h04, BNE = 'h05;
    localparam int BGTZ = 'h07, ADDI = 'h08, LW = 'h23, SH = 'h29, SW = 'h2B;

    logic       clk;
    logic       reset;
    logic [5:0] id_opcode;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       ex_mem_read, branch_taken, imem_ready;

    logic        a_pc, a_ifid, a_flush, a_bub;
    logic [1:0]  a_sel, a_st;
    logic [15:0] a_cnt;
    logic        b_pc, b_ifid, b_flush, b_bub;
    logic [1:0]  b_sel, b_st;
    logic [15:0] b_cnt;
    logic        c_pc, c_ifid, c_flush, c_bub;
    logic [1:0]  c_sel, c_st;
    logic [2:0]  c_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Default configuration: one stall cycle, delay slot executes.
    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .DELAY_SLOT(1'b1), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .pc_load_enable(a_pc), .ifid_load_enable(a_ifid),
        .ifid_flush(a_flush), .idex_bubble(a_bub), .pc_src_sel(a_sel),
        .stall_count(a_cnt), .state_o(a_st));

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .DELAY_SLOT(1'b1), .CNT_W(16)) u_ls3 (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .pc_load_enable(b_pc), .ifid_load_enable(b_ifid),
        .ifid_flush(b_flush), .idex_bubble(b_bub), .pc_src_sel(b_sel),
        .stall_count(b_cnt), .state_o(b_st));

    // No delay slot and a narrow counter so saturation is reachable.
    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .DELAY_SLOT(1'b0), .CNT_W(3)) u_ds0 (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .pc_load_enable(c_pc), .ifid_load_enable(c_ifid),
        .ifid_flush(c_flush), .idex_bubble(c_bub), .pc_src_sel(c_sel),
        .stall_count(c_cnt), .state_o(c_st));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int op, rs, rt, mr, ert, tk;
        int pc, flush, bubble, sel, flush_ds0;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input int op, rs, rt, mr, ert, tk, pc, flush, bubble, sel, flush_ds0);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.mr = mr; v.ert = ert; v.tk = tk;
        v.pc = pc; v.flush = flush; v.bubble = bubble; v.sel = sel; v.flush_ds0 = flush_ds0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic drive(input int op, rs, rt, mr, ert, tk, rdy);
        id_opcode    = 6'(op);
        id_rs        = 5'(rs);
        id_rt        = 5'(rt);
        ex_mem_read  = 1'(mr);
        ex_rt        = 5'(ert);
        branch_taken = 1'(tk);
        imem_ready   = 1'(rdy);
    endtask

    task automatic drive_idle();
        drive(RTYPE, 1, 2, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        //           op     rs rt mr ert tk   pc fl bb sel fl0
        vecs[0]  = mk(RTYPE, 8, 9, 1, 8, 0,   0, 0, 1, 0, 0);
        vecs[1]  = mk(RTYPE, 9, 8, 1, 8, 0,   0, 0, 1, 0, 0);
        vecs[2]  = mk(ADDI,  1, 8, 1, 8, 0,   1, 0, 0, 0, 0);
        vecs[3]  = mk(RTYPE, 8, 9, 0, 8, 0,   1, 0, 0, 0, 0);
        vecs[4]  = mk(RTYPE, 0, 9, 1, 0, 0,   1, 0, 0, 0, 0);
        vecs[5]  = mk(BEQ,   1, 2, 0, 0, 1,   1, 0, 0, 1, 1);
        vecs[6]  = mk(BEQ,   1, 2, 0, 0, 0,   1, 0, 0, 0, 0);
        vecs[7]  = mk(J,     0, 0, 0, 0, 0,   1, 0, 0, 2, 1);
        vecs[8]  = mk(JAL,   0, 0, 0, 0, 1,   1, 0, 0, 2, 1);
        vecs[9]  = mk(BEQ,   1, 2, 1, 2, 1,   0, 0, 1, 0, 0);
        vecs[10] = mk(SW,    3, 8, 1, 8, 0,   0, 0, 1, 0, 0);
        vecs[11] = mk(BGTZ,  1, 8, 1, 8, 1,   1, 0, 0, 1, 1);
        vecs[12] = mk(SH,    4, 5, 1, 5, 0,   0, 0, 1, 0, 0);
        vecs[13] = mk(RTYPE, 0, 0, 1, 0, 0,   1, 0, 0, 0, 0);
        vecs[14] = mk(RTYPE, 1, 2, 0, 0, 1,   1, 0, 0, 0, 0);
        vecs[15] = mk(LW,    8, 9, 1, 8, 0,   0, 0, 1, 0, 0);
        vecs[16] = mk(BNE,   1, 2, 0, 0, 1,   1, 0, 0, 1, 1);

        // Reset state while reset is held low.
        reset = 1'b0;
        drive_idle();
        #2;
        check("rst pc_en",   32'(a_pc),    32'd0);
        check("rst ifid_en", 32'(a_ifid),  32'd0);
        check("rst flush",   32'(a_flush), 32'd0);
        check("rst bubble",  32'(a_bub),   32'd1);
        check("rst sel",     32'(a_sel),   32'd0);
        check("rst count",   32'(a_cnt),   32'd0);
        check("rst state",   32'(a_st),    32'd0);
        @(negedge clk);
        reset = 1'b1;

        // RUN-state decode table; imem always ready so every row starts in RUN.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].mr, vecs[i].ert, vecs[i].tk, 1);
            #2;
            check($sformatf("v%0d pc_en", i),   32'(a_pc),    32'(vecs[i].pc));
            check($sformatf("v%0d ifid_en", i), 32'(a_ifid),  32'(vecs[i].pc));
            check($sformatf("v%0d flush", i),   32'(a_flush), 32'(vecs[i].flush));
            check($sformatf("v%0d bubble", i),  32'(a_bub),   32'(vecs[i].bubble));
            check($sformatf("v%0d sel", i),     32'(a_sel),   32'(vecs[i].sel));
            check($sformatf("v%0d ds0 flush", i), 32'(c_flush), 32'(vecs[i].flush_ds0));
            check($sformatf("v%0d state", i),   32'(a_st),    32'd0);
        end
        @(negedge clk);
        drive_idle();
        #2;
        check("table stall count", 32'(a_cnt), 32'd6);

        // Single-cycle load-use stall.
        do_reset();
        @(negedge clk);
        drive(RTYPE, 8, 9, 1, 8, 0, 1);
        #2;
        check("ls1 pc_en",  32'(a_pc),  32'd0);
        check("ls1 bubble", 32'(a_bub), 32'd1);
        @(negedge clk);
        drive_idle();
        #2;
        check("ls1 resume pc_en", 32'(a_pc),  32'd1);
        check("ls1 state",        32'(a_st),  32'd0);
        check("ls1 count",        32'(a_cnt), 32'd1);

        // Three-cycle load-use stall; hazard removed after the first cycle.
        do_reset();
        @(negedge clk);
        drive(RTYPE, 8, 9, 1, 8, 0, 1);
        #2;
        check("ls3 c0 state", 32'(b_st), 32'd0);
        check("ls3 c0 pc_en", 32'(b_pc), 32'd0);
        @(negedge clk);
        drive_idle();
        #2;
        check("ls3 c1 state",  32'(b_st),  32'd1);
        check("ls3 c1 pc_en",  32'(b_pc),  32'd0);
        check("ls3 c1 bubble", 32'(b_bub), 32'd1);
        @(negedge clk);
        #2;
        check("ls3 c2 state", 32'(b_st), 32'd1);
        check("ls3 c2 pc_en", 32'(b_pc), 32'd0);
        @(negedge clk);
        #2;
        check("ls3 c3 state", 32'(b_st),  32'd0);
        check("ls3 c3 pc_en", 32'(b_pc),  32'd1);
        check("ls3 count",    32'(b_cnt), 32'd3);

        // Taken beq while imem is not ready: redirect is held until the word arrives.
        do_reset();
        @(negedge clk);
        drive(BEQ, 1, 2, 0, 0, 1, 0);
        #2;
        check("mw c0 state",  32'(a_st),  32'd0);
        check("mw c0 pc_en",  32'(a_pc),  32'd0);
        check("mw c0 bubble", 32'(a_bub), 32'd1);
        check("mw c0 sel",    32'(a_sel), 32'd0);
        @(negedge clk);
        drive(RTYPE, 1, 2, 0, 0, 0, 0);
        #2;
        check("mw c1 state", 32'(a_st), 32'd2);
        check("mw c1 pc_en", 32'(a_pc), 32'd0);
        @(negedge clk);
        drive_idle();
        #2;
        check("mw rel state",     32'(a_st),    32'd2);
        check("mw rel pc_en",     32'(a_pc),    32'd1);
        check("mw rel sel",       32'(a_sel),   32'd1);
        check("mw rel flush",     32'(a_flush), 32'd0);
        check("mw rel ds0 sel",   32'(c_sel),   32'd1);
        check("mw rel ds0 flush", 32'(c_flush), 32'd1);
        @(negedge clk);
        #2;
        check("mw after state", 32'(a_st),    32'd0);
        check("mw after sel",   32'(a_sel),   32'd0);
        check("mw after flush", 32'(c_flush), 32'd0);
        check("mw count",       32'(a_cnt),   32'd2);

        // Reset asserted in the middle of a load stall.
        do_reset();
        @(negedge clk);
        drive(RTYPE, 8, 9, 1, 8, 0, 1);
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        #2;
        check("rs stall state",   32'(b_st),    32'd0);
        check("rs stall pc_en",   32'(b_pc),    32'd0);
        check("rs stall ifid_en", 32'(b_ifid),  32'd0);
        check("rs stall flush",   32'(b_flush), 32'd0);
        check("rs stall bubble",  32'(b_bub),   32'd1);
        check("rs stall sel",     32'(b_sel),   32'd0);
        check("rs stall count",   32'(b_cnt),   32'd0);
        @(negedge clk);
        reset = 1'b1;
        #2;
        check("rs post state", 32'(b_st), 32'd0);
        check("rs post pc_en", 32'(b_pc), 32'd1);
        @(negedge clk);
        #2;
        check("rs post count", 32'(b_cnt), 32'd0);

        // Reset during a memory wait discards the pending jump.
        @(negedge clk);
        drive(J, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        check("rw wait state", 32'(a_st), 32'd2);
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("rw rst state", 32'(a_st), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        drive_idle();
        #2;
        check("rw post sel",   32'(a_sel), 32'd0);
        check("rw post pc_en", 32'(a_pc),  32'd1);

        // Long memory wait saturates the 3-bit counter but not the 16-bit one.
        do_reset();
        @(negedge clk);
        drive(RTYPE, 1, 2, 0, 0, 0, 0);
        repeat (7) @(negedge clk);
        #2;
        check("sat ds0 count 7", 32'(c_cnt), 32'd7);
        repeat (3) @(negedge clk);
        #2;
        check("sat ds0 count hold", 32'(c_cnt), 32'd7);
        check("sat dut count 10",   32'(a_cnt), 32'd10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
